warp_sequencer: RTL and testbench
=================================

WARP_SEQUENCER -- requirements
Module: warp_sequencer

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, meaning number of warps sequenced (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default `DATA_WIDTH, meaning width of the issue counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  block launch request, sampled in WARP_IDLE only.
REQ-006 SHALL have port warp_active  input  NUM_WARPS  warps present in the block, captured on accepted start.
REQ-007 SHALL have port fetch_valid  input  1  instruction for the current warp available.
REQ-008 SHALL have port decoded_ret  input  1  current instruction is a return, sampled in WARP_UPDATE.
REQ-009 SHALL have port lsu_busy  input  1  any thread's LSU access outstanding.
REQ-010 SHALL have port warp_state  output  warp_state_t  phase driven to reg_file/ALU/LSU.
REQ-011 SHALL have port warp_enable  output  NUM_WARPS  one-hot enable of the current warp; zero in WARP_IDLE/WARP_DONE.
REQ-012 SHALL have port current_warp  output  $clog2(NUM_WARPS) (min 1)  index of the current warp.
REQ-013 SHALL have port done  output  1  all captured warps have returned.
REQ-014 SHALL have port issue_count  output  DATA_WIDTH  number of completed WARP_UPDATE cycles since start.

Function
REQ-015 SHALL implement states WARP_IDLE, WARP_FETCH, WARP_DECODE, WARP_REQUEST, WARP_WAIT, WARP_EXECUTE, WARP_UPDATE, WARP_DONE, output directly on warp_state.
REQ-016 WARP_IDLE: on start=1 and warp_active!=0 SHALL capture warp_active into active mask, clear done mask and issue_count, select lowest-index active warp, go to WARP_FETCH next cycle.
REQ-017 WARP_IDLE: on start=1 and warp_active==0 SHALL go directly to WARP_DONE.
REQ-018 WARP_FETCH SHALL hold while fetch_valid=0 and go to WARP_DECODE the cycle after fetch_valid=1.
REQ-019 WARP_DECODE, WARP_REQUEST, WARP_EXECUTE, WARP_UPDATE SHALL each last exactly one cycle, in order DECODE->REQUEST->WAIT, EXECUTE->UPDATE.
REQ-020 WARP_WAIT SHALL last at least one cycle and hold while lsu_busy=1; go to WARP_EXECUTE the cycle after lsu_busy=0 is sampled.
REQ-021 WARP_UPDATE SHALL increment issue_count by 1 (wraps at 2^DATA_WIDTH) and, if decoded_ret=1, set the current warp's bit in the done mask.
REQ-022 After WARP_UPDATE SHALL pick next warp round-robin: first index after current_warp (modulo NUM_WARPS, current warp considered last) that is active and not done, including the just-updated done bit.
REQ-023 If no active, not-done warp remains after WARP_UPDATE SHALL go to WARP_DONE; otherwise WARP_FETCH with the new current_warp.
REQ-024 A single remaining warp SHALL be reselected itself each instruction.
REQ-025 WARP_DONE SHALL assert done=1 and remain until reset; start ignored.
REQ-026 warp_active changes after capture SHALL have no effect until next start from WARP_IDLE.
REQ-027 fetch_valid, decoded_ret and lsu_busy SHALL be ignored in states that do not sample them.
REQ-028 warp_enable SHALL equal 1<<current_warp in all states except WARP_IDLE and WARP_DONE.

Reset
REQ-029 reset=1 SHALL force, at the next edge: warp_state=WARP_IDLE, current_warp=0, warp_enable=0, done=0, issue_count=0, active and done masks=0, regardless of state (including mid-WAIT).
REQ-030 reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-031 NUM_WARPS=4, warp_active=4'b1011, fetch_valid=1, lsu_busy=0, decoded_ret=0 -> warps issued 0,1,3,0,1,3...; each instruction 6 cycles FETCH..UPDATE.
REQ-032 Same, decoded_ret=1 on warp 1's first UPDATE -> order 0,1,3,0,3,0; done mask excludes warp 1 thereafter.
REQ-033 lsu_busy held 1 for 5 cycles entering WARP_WAIT -> WAIT lasts 6 cycles, then EXECUTE; fetch_valid=0 for 3 cycles holds FETCH 4 cycles.
REQ-034 warp_active=4'b0001, decoded_ret=1 on first UPDATE -> WARP_DONE, done=1, issue_count=1, warp_enable=0 next cycle; start pulses ignored.
REQ-035 start with warp_active=0 -> WARP_DONE next cycle, issue_count=0.
REQ-036 reset asserted during WARP_WAIT with lsu_busy=1 -> all outputs at reset values next cycle; fresh start relaunches from lowest active warp.

Source files
------------

// File: rtl/warp_sequencer_if.sv
// Warp sequencer phase type and the launch/fetch/LSU signal bundle between
// the sequencer and the core datapath.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package warp_sequencer_pkg;
    typedef enum logic [2:0] {
        WARP_IDLE,
        WARP_FETCH,
        WARP_DECODE,
        WARP_REQUEST,
        WARP_WAIT,
        WARP_EXECUTE,
        WARP_UPDATE,
        WARP_DONE
    } warp_state_t;
endpackage

interface warp_sequencer_if
    import warp_sequencer_pkg::*;
#(
    parameter int NUM_WARPS  = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH
);
    localparam int CW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    // Handshake: there is no ready path back to the producers. start,
    // fetch_valid, decoded_ret and lsu_busy are levels that the sequencer
    // samples only in the phase that consumes them (IDLE, FETCH, UPDATE, WAIT)
    // and ignores elsewhere; a producer holds its level until that phase.
    logic                  start;
    logic [NUM_WARPS-1:0]  warp_active;
    logic                  fetch_valid;
    logic                  decoded_ret;
    logic                  lsu_busy;
    warp_state_t           warp_state;
    logic [NUM_WARPS-1:0]  warp_enable;
    logic [CW-1:0]         current_warp;
    logic                  done;
    logic [DATA_WIDTH-1:0] issue_count;

    modport master (
        output start, warp_active, fetch_valid, decoded_ret, lsu_busy,
        input  warp_state, warp_enable, current_warp, done, issue_count
    );

    modport slave (
        input  start, warp_active, fetch_valid, decoded_ret, lsu_busy,
        output warp_state, warp_enable, current_warp, done, issue_count
    );
endinterface

// File: rtl/warp_sequencer.sv
// Round-robin warp sequencer: steps each active warp through the
// FETCH..UPDATE instruction phases until every captured warp has returned.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module warp_sequencer
    import warp_sequencer_pkg::*;
#(
    parameter int NUM_WARPS  = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    warp_sequencer_if.slave  bus
);
    localparam int CW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    warp_state_t           state;
    logic [CW-1:0]         cur;
    logic [NUM_WARPS-1:0]  enable;
    logic                  done_r;
    logic [DATA_WIDTH-1:0] count;
    logic [NUM_WARPS-1:0]  active_mask;
    logic [NUM_WARPS-1:0]  done_mask;

    logic [NUM_WARPS-1:0]  upd_done;
    logic [NUM_WARPS-1:0]  avail;
    logic [CW-1:0]         next_warp;
    logic                  any_left;
    logic [CW-1:0]         first_warp;
    logic [CW-1:0]         idx;

    assign bus.warp_state   = state;
    assign bus.current_warp = cur;
    assign bus.warp_enable  = enable;
    assign bus.done         = done_r;
    assign bus.issue_count  = count;

    function automatic logic [NUM_WARPS-1:0] onehot(input logic [CW-1:0] w);
        logic [NUM_WARPS-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    // Scan descending so the nearest index after cur wins; cur itself
    // (offset NUM_WARPS) is the last candidate considered.
    always_comb begin
        upd_done = done_mask;
        if (bus.decoded_ret) upd_done[cur] = 1'b1;
        avail     = active_mask & ~upd_done;
        next_warp = cur;
        any_left  = 1'b0;
        idx       = '0;
        for (int i = NUM_WARPS; i >= 1; i--) begin
            idx = CW'((int'(cur) + i) % NUM_WARPS);
            if (avail[idx]) begin
                next_warp = idx;
                any_left  = 1'b1;
            end
        end
        first_warp = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (bus.warp_active[i]) first_warp = CW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WARP_IDLE;
            cur         <= '0;
            enable      <= '0;
            done_r      <= 1'b0;
            count       <= '0;
            active_mask <= '0;
            done_mask   <= '0;
        end else begin
            case (state)
                WARP_IDLE: begin
                    if (bus.start) begin
                        count <= '0;
                        if (|bus.warp_active) begin
                            active_mask <= bus.warp_active;
                            done_mask   <= '0;
                            cur         <= first_warp;
                            enable      <= onehot(first_warp);
                            state       <= WARP_FETCH;
                        end else begin
                            done_r <= 1'b1;
                            state  <= WARP_DONE;
                        end
                    end
                end
                WARP_FETCH:   if (bus.fetch_valid) state <= WARP_DECODE;
                WARP_DECODE:  state <= WARP_REQUEST;
                WARP_REQUEST: state <= WARP_WAIT;
                WARP_WAIT:    if (!bus.lsu_busy) state <= WARP_EXECUTE;
                WARP_EXECUTE: state <= WARP_UPDATE;
                WARP_UPDATE: begin
                    count     <= count + 1'b1;
                    done_mask <= upd_done;
                    if (any_left) begin
                        cur    <= next_warp;
                        enable <= onehot(next_warp);
                        state  <= WARP_FETCH;
                    end else begin
                        enable <= '0;
                        done_r <= 1'b1;
                        state  <= WARP_DONE;
                    end
                end
                WARP_DONE:    state <= WARP_DONE;
                default:      state <= WARP_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_warp_sequencer.sv
// Directed bench for warp_sequencer: issue order is scoreboarded from the
// UPDATE phase, phase timing and reset behaviour are checked inline.
module tb_warp_sequencer;
    import warp_sequencer_pkg::*;

    localparam int NW = 4;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;
    logic [1:0] exp_q[$];

    warp_sequencer_if #(.NUM_WARPS(NW), .DATA_WIDTH(DW)) bus ();

    warp_sequencer #(.NUM_WARPS(NW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within budget");
        $fatal(1, "timeout");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_phase(input string tag, input warp_state_t s);
        check(tag, 32'(bus.warp_state), 32'(s));
    endtask

    // Scoreboard: every UPDATE phase consumes the next expected warp.
    always @(negedge clk) begin
        if (!reset && bus.warp_state == WARP_UPDATE) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", 32'(bus.current_warp), 32'hFFFF_FFFF);
            end else begin
                check("issue_order", 32'(bus.current_warp), 32'(exp_q.pop_front()));
            end
            check("update_enable", 32'(bus.warp_enable), 32'(4'b0001 << bus.current_warp));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.warp_active = '0;
        bus.fetch_valid = 1'b1;
        bus.decoded_ret = 1'b0;
        bus.lsu_busy    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic launch(input logic [NW-1:0] mask);
        bus.warp_active = mask;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_phase({tag, "_state"}, WARP_IDLE);
        check({tag, "_cur"},    32'(bus.current_warp), 32'd0);
        check({tag, "_enable"}, 32'(bus.warp_enable),  32'd0);
        check({tag, "_done"},   32'(bus.done),         32'd0);
        check({tag, "_count"},  32'(bus.issue_count),  32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.warp_active = '0;
        bus.fetch_valid = 1'b0;
        bus.decoded_ret = 1'b0;
        bus.lsu_busy    = 1'b0;

        // Plain round-robin over 1011, six cycles per instruction.
        do_reset();
        check_reset_values("rst");
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        launch(4'b1011);
        check_phase("rr_fetch0", WARP_FETCH);
        check("rr_cur0", 32'(bus.current_warp), 32'd0);
        check("rr_en0",  32'(bus.warp_enable),  32'b0001);
        cycles(1); check_phase("rr_decode", WARP_DECODE);
        cycles(1); check_phase("rr_request", WARP_REQUEST);
        cycles(1); check_phase("rr_wait", WARP_WAIT);
        cycles(1); check_phase("rr_execute", WARP_EXECUTE);
        cycles(1); check_phase("rr_update", WARP_UPDATE);
        cycles(1); check_phase("rr_fetch1", WARP_FETCH);
        check("rr_cur1",   32'(bus.current_warp), 32'd1);
        check("rr_en1",    32'(bus.warp_enable),  32'b0010);
        check("rr_count1", 32'(bus.issue_count),  32'd1);
        cycles(30);
        check_phase("rr_fetch6", WARP_FETCH);
        check("rr_cur6",   32'(bus.current_warp), 32'd0);
        check("rr_count6", 32'(bus.issue_count),  32'd6);
        check("rr_drain",  32'(exp_q.size()),     32'd0);

        // Warp 1 returns on its first UPDATE and drops out of the rotation.
        do_reset();
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        exp_q.push_back(2'd0); exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        launch(4'b1011);
        cycles(11);
        check_phase("ret_update", WARP_UPDATE);
        check("ret_cur", 32'(bus.current_warp), 32'd1);
        bus.decoded_ret = 1'b1;
        cycles(1);
        bus.decoded_ret = 1'b0;
        check("ret_next", 32'(bus.current_warp), 32'd3);
        cycles(24);
        check_phase("ret_fetch", WARP_FETCH);
        check("ret_cur_end", 32'(bus.current_warp), 32'd3);
        check("ret_count",   32'(bus.issue_count),  32'd6);
        check("ret_drain",   32'(exp_q.size()),     32'd0);

        // FETCH stall of 3 cycles and an LSU stall of 5 cycles.
        do_reset();
        bus.fetch_valid = 1'b0;
        exp_q.push_back(2'd0);
        launch(4'b0001);
        cycles(3);
        check_phase("stall_fetch4", WARP_FETCH);
        bus.fetch_valid = 1'b1;
        cycles(1); check_phase("stall_decode", WARP_DECODE);
        cycles(1); check_phase("stall_request", WARP_REQUEST);
        bus.lsu_busy = 1'b1;
        cycles(1); check_phase("stall_wait1", WARP_WAIT);
        cycles(5); check_phase("stall_wait6", WARP_WAIT);
        bus.lsu_busy = 1'b0;
        cycles(1); check_phase("stall_execute", WARP_EXECUTE);
        cycles(2);
        check_phase("stall_fetch_next", WARP_FETCH);
        check("stall_count", 32'(bus.issue_count), 32'd1);
        check("stall_drain", 32'(exp_q.size()),    32'd0);

        // Single warp returning on its first instruction finishes the block.
        do_reset();
        bus.decoded_ret = 1'b1;
        exp_q.push_back(2'd0);
        launch(4'b0001);
        cycles(6);
        check_phase("one_done", WARP_DONE);
        check("one_done_flag", 32'(bus.done),        32'd1);
        check("one_count",     32'(bus.issue_count), 32'd1);
        check("one_enable",    32'(bus.warp_enable), 32'd0);
        launch(4'b1111);
        cycles(1);
        check_phase("one_start_ignored", WARP_DONE);
        check("one_count_hold", 32'(bus.issue_count), 32'd1);
        check("one_drain",      32'(exp_q.size()),    32'd0);

        // Empty block goes straight to DONE.
        do_reset();
        launch(4'b0000);
        check_phase("empty_done", WARP_DONE);
        check("empty_flag",   32'(bus.done),        32'd1);
        check("empty_count",  32'(bus.issue_count), 32'd0);
        check("empty_enable", 32'(bus.warp_enable), 32'd0);

        // Reset mid-WAIT with LSU busy, racing a start, then relaunch.
        do_reset();
        bus.lsu_busy = 1'b1;
        launch(4'b1010);
        check("mid_cur", 32'(bus.current_warp), 32'd1);
        check("mid_en",  32'(bus.warp_enable),  32'b0010);
        cycles(4);
        check_phase("mid_wait", WARP_WAIT);
        reset     = 1'b1;
        bus.start = 1'b1;
        cycles(1);
        check_reset_values("mid_rst");
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.lsu_busy = 1'b0;
        exp_q.push_back(2'd1); exp_q.push_back(2'd3);
        launch(4'b1010);
        check_phase("relaunch_fetch", WARP_FETCH);
        check("relaunch_cur", 32'(bus.current_warp), 32'd1);
        check("relaunch_en",  32'(bus.warp_enable),  32'b0010);
        cycles(12);
        check("relaunch_cur2",  32'(bus.current_warp), 32'd1);
        check("relaunch_count", 32'(bus.issue_count),  32'd2);
        check("relaunch_drain", 32'(exp_q.size()),     32'd0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
